mul_hilo_unit: RTL

- Downstream consumer of the single-cycle multiplier's 64-bit response stream.
- Owns the architectural HI/LO register pair.
- Per multiply, an issue-side descriptor (operation kind, sign-correction flag) is queued in program order when the request is sent to the multiplier.
- The matching product is then written, accumulated or subtracted into HI:LO.
- Also serves the direct HI/LO writes and provides a busy interlock for reads.

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_hilo_unit_if.sv | 32 +++
 rtl/mul_desc_fifo.sv | 50 +++++
 rtl/mul_hilo_unit.sv | 81 ++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the HI/LO unit: op encodings, descriptor layout,
// product width.
package mul_pkg;

    localparam int PROD_W = 64;

    localparam logic [1:0] MUL_OP_WRITE = 2'b00;
    localparam logic [1:0] MUL_OP_ADD   = 2'b01;
    localparam logic [1:0] MUL_OP_SUB   = 2'b10;

    // Issue-side descriptor queued per multiply, in program order.
    typedef struct packed {
        logic [1:0] kind;
        logic       neg;
    } mul_desc_t;

endpackage

// File: rtl/mul_hilo_unit_if.sv
// Bus between the core (master) and the HI/LO unit (slave): descriptor
// issue, product stream, direct HI/LO writes and architectural state.
interface mul_hilo_unit_if;

    logic        op_val;
    logic        op_rdy;
    logic [1:0]  op_kind;
    logic        op_neg;
    logic [63:0] mul_out;
    logic        mul_val;
    logic        mul_rdy;
    logic        wr_hi_en;
    logic        wr_lo_en;
    logic [31:0] wr_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        err;

    modport master (
        output op_val, op_kind, op_neg, mul_out, mul_val,
               wr_hi_en, wr_lo_en, wr_data,
        input  op_rdy, mul_rdy, hi, lo, busy, err
    );

    modport slave (
        input  op_val, op_kind, op_neg, mul_out, mul_val,
               wr_hi_en, wr_lo_en, wr_data,
        output op_rdy, mul_rdy, hi, lo, busy, err
    );

endinterface

// File: rtl/mul_desc_fifo.sv
// Small descriptor FIFO. Caller gates push with !full and pop with !empty;
// pointers wrap naturally because DEPTH is a power of two.
module mul_desc_fifo
    import mul_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  mul_desc_t       push_data,
    input  logic            pop,
    output mul_desc_t       pop_data,
    output logic [PTR_W:0]  count,
    output logic            full,
    output logic            empty
);

    mul_desc_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign pop_data = mem[rd_ptr];
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);

    // Storage needs no reset; entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointers and occupancy; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_hilo_unit.sv
// HI/LO register pair fed by the multiplier's product stream. Each product
// is paired with the oldest queued descriptor and written, added or
// subtracted into HI:LO; direct mthi/mtlo writes are honoured only when idle.
module mul_hilo_unit
    import mul_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    mul_hilo_unit_if.slave   bus
);

    logic              push;
    logic              done;
    logic              full;
    logic              empty;
    logic [PTR_W:0]    count;
    mul_desc_t         in_desc;
    mul_desc_t         head;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic              err_q;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] hilo_nxt;

    // Ready/busy look only at registered occupancy: no bypass either way.
    assign bus.op_rdy  = !full;
    assign bus.mul_rdy = !empty;
    assign bus.busy    = (count != '0);
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.err     = err_q;

    assign push    = bus.op_val && !full;
    assign done    = bus.mul_val && !empty;
    assign in_desc = '{kind: bus.op_kind, neg: bus.op_neg};

    mul_desc_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_desc),
        .pop       (done),
        .pop_data  (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Sign-fix the product, then combine with HI:LO; reserved kind acts as WRITE.
    always_comb begin
        prod     = head.neg ? (~bus.mul_out + PROD_W'(1)) : bus.mul_out;
        hilo_nxt = prod;
        case (head.kind)
            MUL_OP_ADD: hilo_nxt = {hi_q, lo_q} + prod;
            MUL_OP_SUB: hilo_nxt = {hi_q, lo_q} - prod;
            default:    hilo_nxt = prod;
        endcase
    end

    // HI/LO update: completion wins; direct writes land only when nothing pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (done) begin
                {hi_q, lo_q} <= hilo_nxt;
            end else if (!bus.busy) begin
                if (bus.wr_hi_en) hi_q <= bus.wr_data;
                if (bus.wr_lo_en) lo_q <= bus.wr_data;
            end
            if ((bus.wr_hi_en || bus.wr_lo_en) && (bus.busy || done))
                err_q <= 1'b1;
        end
    end

endmodule
